fs_dither_engine: RTL and testbench



---
 rtl/fs_dither_engine.sv | 249 ++++++++++++++++++++++++
 tb/tb_fs_dither_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fs_dither_engine.sv
// Floyd-Steinberg error-diffusion engine on SRAM port B.
// Reads each pixel in raster order, thresholds it to 0x00/0xFF, writes it back
// in place and spreads the quantisation error right (carry register) and to the
// row below (ping-ponged row error buffers).
module fs_dither_engine #(
    parameter int WIDTH      = 256,
    parameter int HEIGHT     = 256,
    parameter int ADDR_W     = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic              MAX10_CLK1_50,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int XW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int YW = 16;
    localparam logic [XW-1:0]     X_LAST    = XW'(WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(HEIGHT - 1);
    localparam logic [1:0]        WAIT_LAST = 2'(RD_LATENCY - 1);
    localparam logic signed [11:0] V_MAX    = 12'sd511;
    localparam logic signed [11:0] V_MIN    = -12'sd256;
    localparam logic signed [11:0] V_THR    = 12'sd128;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_CALC = 3'd3,
        ST_WR   = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    // Weighted share of the error: floor((e * k) / 16).
    function automatic logic signed [10:0] err_term(input logic signed [9:0] e,
                                                    input logic [3:0]        k);
        logic signed [14:0] prod;
        prod = 15'(e) * $signed({11'd0, k});
        return 11'(prod >>> 4);
    endfunction

    state_t                state_r;
    state_t                state_nxt_s;
    logic [XW-1:0]         x_r;
    logic [YW-1:0]         y_r;
    logic [ADDR_W-1:0]     addr_r;
    logic                  first_row_r;
    logic                  sel_r;
    logic signed [10:0]    carry_r;
    logic [1:0]            wait_cnt_r;
    logic [7:0]            pix_r;
    logic signed [9:0]     e_r;
    logic [7:0]            wdata_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  rden_r;
    logic                  wren_r;

    // Two row buffers: err_r[sel_r] feeds the current row, err_r[~sel_r] collects the next.
    logic signed [10:0]    err_r [2][WIDTH];

    logic signed [10:0]    cur_err_s;
    logic signed [11:0]    v_raw_s;
    logic signed [11:0]    v_sat_s;
    logic [7:0]            out_s;
    logic signed [9:0]     e_s;
    logic signed [10:0]    t1_s;
    logic signed [10:0]    t3_s;
    logic signed [10:0]    t5_s;
    logic signed [10:0]    t7_s;
    logic                  nsel_s;
    logic [XW-1:0]         x_dec_s;
    logic [XW-1:0]         x_inc_s;

    assign busy      = busy_r;
    assign done      = done_r;
    assign mem_addr  = addr_r;
    assign mem_rden  = rden_r;
    assign mem_wren  = wren_r;
    assign mem_wdata = wdata_r;

    // State register.
    always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; start is only looked at in IDLE, so FIN and busy states ignore it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_RD;
                else       state_nxt_s = ST_IDLE;
            end
            ST_RD:   state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) state_nxt_s = ST_CALC;
                else                         state_nxt_s = ST_WAIT;
            end
            ST_CALC: state_nxt_s = ST_WR;
            ST_WR: begin
                if ((x_r == X_LAST) && (y_r == Y_LAST)) state_nxt_s = ST_FIN;
                else                                    state_nxt_s = ST_RD;
            end
            ST_FIN:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Pixel arithmetic: add diffused error, saturate, threshold, residual error.
    always_comb begin
        cur_err_s = 11'sd0;
        v_raw_s   = 12'sd0;
        v_sat_s   = 12'sd0;
        out_s     = 8'h00;
        e_s       = 10'sd0;
        if (first_row_r) begin
            cur_err_s = 11'sd0;
        end else begin
            cur_err_s = err_r[sel_r][x_r];
        end
        v_raw_s = {4'd0, pix_r} + {cur_err_s[10], cur_err_s} + {carry_r[10], carry_r};
        if (v_raw_s > V_MAX) begin
            v_sat_s = V_MAX;
        end else if (v_raw_s < V_MIN) begin
            v_sat_s = V_MIN;
        end else begin
            v_sat_s = v_raw_s;
        end
        if (v_sat_s >= V_THR) begin
            out_s = 8'hFF;
        end else begin
            out_s = 8'h00;
        end
        e_s = 10'(v_sat_s - $signed({4'd0, out_s}));
    end

    // Error shares and neighbour indices used during WR.
    always_comb begin
        t1_s    = err_term(e_r, 4'd1);
        t3_s    = err_term(e_r, 4'd3);
        t5_s    = err_term(e_r, 4'd5);
        t7_s    = err_term(e_r, 4'd7);
        nsel_s  = ~sel_r;
        x_dec_s = x_r - XW'(1);
        x_inc_s = x_r + XW'(1);
    end

    // Next-row buffer update. Entry x+1 (and entry 0 at row start) is overwritten so
    // stale contents from two rows ago never leak in.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (state_r == ST_WR) begin
            if (x_r != {XW{1'b0}}) begin
                err_r[nsel_s][x_dec_s] <= err_r[nsel_s][x_dec_s] + t3_s;
                err_r[nsel_s][x_r]     <= err_r[nsel_s][x_r] + t5_s;
            end else begin
                err_r[nsel_s][x_r]     <= t5_s;
            end
            if (x_r != X_LAST) begin
                err_r[nsel_s][x_inc_s] <= t1_s;
            end
        end
    end

    // Frame position, read capture, right carry and buffer swap.
    always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
        if (rst) begin
            x_r         <= {XW{1'b0}};
            y_r         <= {YW{1'b0}};
            addr_r      <= {ADDR_W{1'b0}};
            first_row_r <= 1'b1;
            sel_r       <= 1'b0;
            carry_r     <= 11'sd0;
            wait_cnt_r  <= 2'd0;
            pix_r       <= 8'h00;
            e_r         <= 10'sd0;
            wdata_r     <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        x_r         <= {XW{1'b0}};
                        y_r         <= {YW{1'b0}};
                        addr_r      <= {ADDR_W{1'b0}};
                        first_row_r <= 1'b1;
                        carry_r     <= 11'sd0;
                    end
                end
                ST_RD: begin
                    wait_cnt_r <= 2'd0;
                end
                ST_WAIT: begin
                    wait_cnt_r <= wait_cnt_r + 2'd1;
                    if (wait_cnt_r == WAIT_LAST) begin
                        pix_r <= mem_rdata;
                    end
                end
                ST_CALC: begin
                    wdata_r <= out_s;
                    e_r     <= e_s;
                end
                ST_WR: begin
                    addr_r <= addr_r + ADDR_W'(1);
                    if (x_r == X_LAST) begin
                        carry_r     <= 11'sd0;
                        x_r         <= {XW{1'b0}};
                        y_r         <= y_r + 16'd1;
                        sel_r       <= ~sel_r;
                        first_row_r <= 1'b0;
                    end else begin
                        carry_r <= t7_s;
                        x_r     <= x_inc_s;
                    end
                end
                default: begin
                    wait_cnt_r <= 2'd0;
                end
            endcase
        end
    end

    // Registered strobes, aligned with the state they belong to.
    always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            rden_r <= 1'b0;
            wren_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == ST_RD) || (state_nxt_s == ST_WAIT) ||
                      (state_nxt_s == ST_CALC) || (state_nxt_s == ST_WR);
            done_r <= (state_nxt_s == ST_FIN);
            rden_r <= (state_nxt_s == ST_RD);
            wren_r <= (state_nxt_s == ST_WR);
        end
    end

endmodule

// File: tb/tb_fs_dither_engine.sv
// Randomised bench for fs_dither_engine on a 4x4 frame, RD_LATENCY=2, with a
// latency-2 SRAM model and a whole-frame Floyd-Steinberg reference model.
module tb_fs_dither_engine;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int N   = W * H;
    localparam int LAT = N * 5 + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] mem_addr;
    logic        mem_rden;
    logic        mem_wren;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem      [N];
    logic [7:0]  init_mem [N];
    logic [7:0]  src_px   [N];
    logic [7:0]  exp_px   [N];
    logic [7:0]  rd_pipe;
    logic        load;
    logic        clr;
    int          rd_cnt;
    int          wr_cnt;
    logic        overlap;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fs_dither_engine #(.WIDTH(W), .HEIGHT(H), .ADDR_W(16), .RD_LATENCY(2)) dut (
        .MAX10_CLK1_50 (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .mem_addr      (mem_addr),
        .mem_rden      (mem_rden),
        .mem_wren      (mem_wren),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    // SRAM port B model: two-cycle read pipeline, write on wren, access counters.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < N; i++) mem[i] <= init_mem[i];
        end else if (mem_wren) begin
            mem[mem_addr[3:0]] <= mem_wdata;
        end
        if (mem_rden) rd_pipe <= mem[mem_addr[3:0]];
        mem_rdata <= rd_pipe;
        if (clr) begin
            rd_cnt  <= 0;
            wr_cnt  <= 0;
            overlap <= 1'b0;
        end else begin
            if (mem_rden) rd_cnt <= rd_cnt + 1;
            if (mem_wren) wr_cnt <= wr_cnt + 1;
            if (mem_rden && mem_wren) overlap <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: classic Floyd-Steinberg over a full-frame error accumulator.
    task automatic build_expect();
        int acc [H][W];
        int v;
        int o;
        int e;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) acc[r][c] = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                v = int'(src_px[r*W+c]) + acc[r][c];
                if (v > 511)  v = 511;
                if (v < -256) v = -256;
                o = (v >= 128) ? 255 : 0;
                e = v - o;
                exp_px[r*W+c] = 8'(o);
                if (c < W-1) acc[r][c+1] += (e * 7) >>> 4;
                if (r < H-1) begin
                    if (c > 0) acc[r+1][c-1] += (e * 3) >>> 4;
                    acc[r+1][c] += (e * 5) >>> 4;
                    if (c < W-1) acc[r+1][c+1] += (e * 1) >>> 4;
                end
            end
        end
    endtask

    task automatic load_frame();
        for (int i = 0; i < N; i++) init_mem[i] = src_px[i];
        build_expect();
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    task automatic run_frame(input bit poke_busy, input bit poke_done);
        int cyc;
        int extra;
        bit busy_ok;
        bit got_done;
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        start    = 1'b1;
        cyc      = 0;
        busy_ok  = 1'b1;
        got_done = 1'b0;
        while (!got_done && cyc < 200) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) begin
                got_done = 1'b1;
                if (busy) busy_ok = 1'b0;
                if (poke_done) start = 1'b1;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (poke_busy && cyc == 12) start = 1'b1;
            end
        end
        check_eq("done_seen", int'(got_done), 1);
        check_eq("done_latency", cyc, LAT);
        check_eq("busy_during_frame", int'(busy_ok), 1);
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            start = 1'b0;
            if (done || busy) extra++;
        end
        check_eq("no_extra_activity", extra, 0);
        check_eq("read_count", rd_cnt, N);
        check_eq("write_count", wr_cnt, N);
        check_eq("rd_wr_overlap", int'(overlap), 0);
        for (int i = 0; i < N; i++) check_eq($sformatf("pix%0d", i), int'(mem[i]), int'(exp_px[i]));
    endtask

    initial begin
        int cyc;
        int dn;
        rst   = 1'b1;
        start = 1'b0;
        load  = 1'b0;
        clr   = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_rden", int'(mem_rden), 0);
        check_eq("rst_wren", int'(mem_wren), 0);
        check_eq("rst_addr", int'(mem_addr), 0);
        check_eq("rst_wdata", int'(mem_wdata), 0);
        rst = 1'b0;
        clr = 1'b0;
        @(negedge clk);

        // Directed: flat 120 frame, all black, all white.
        for (int i = 0; i < N; i++) src_px[i] = 8'd120;
        load_frame();
        run_frame(1'b0, 1'b0);
        for (int i = 0; i < N; i++) src_px[i] = 8'd0;
        load_frame();
        run_frame(1'b0, 1'b0);
        for (int i = 0; i < N; i++) src_px[i] = 8'd255;
        load_frame();
        run_frame(1'b0, 1'b0);

        // Random frames, some full-range, some clustered around the threshold.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) begin
                if (f % 2 == 0) src_px[i] = 8'($urandom_range(0, 255));
                else            src_px[i] = 8'($urandom_range(100, 160));
            end
            load_frame();
            run_frame(f == 2, f == 3);
        end

        // Reset during the write of pixel 5.
        for (int i = 0; i < N; i++) src_px[i] = 8'($urandom_range(0, 255));
        load_frame();
        @(negedge clk) start = 1'b1;
        cyc = 0;
        while (cyc < 30) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        check_eq("p5_wren", int'(mem_wren), 1);
        check_eq("p5_addr", int'(mem_addr), 5);
        rst = 1'b1;
        #1;
        check_eq("async_wren_drop", int'(mem_wren), 0);
        check_eq("async_busy_drop", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
        end
        check_eq("abort_no_done", dn, 0);
        for (int i = 0; i < 5; i++) check_eq($sformatf("abort_done_pix%0d", i), int'(mem[i]), int'(exp_px[i]));
        for (int i = 5; i < N; i++) check_eq($sformatf("abort_kept_pix%0d", i), int'(mem[i]), int'(src_px[i]));

        // Reprocess whatever the frame holds now.
        for (int i = 0; i < N; i++) src_px[i] = mem[i];
        build_expect();
        run_frame(1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
